hazard_sched: RTL and testbench
===============================

// Module: hazard_sched
// PURPOSE
//  Pipeline hazard scheduler for the 5-stage MIPS core; sits beside the EX-stage forwarding unit.
//  Covers hazards forwarding cannot: load-use, branch-in-ID operand dependencies, multi-cycle MUL occupancy.
//  Drives PC/IFID write enables, IFID flush and IDEX bubble insertion.
//  Keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  MUL_LAT   4   cycles the EX stage is held for a MUL/MULT op (>=2)
//  CNT_W     32  width of StallCycles counter
// PORTS
//  Clk            in   1      clock, rising edge
//  Rst            in   1      asynchronous, active-low reset
//  IFID_Rs        in   5      source reg Rs of instruction in ID
//  IFID_Rt        in   5      source reg Rt of instruction in ID
//  IFID_UsesRt    in   1      ID instruction reads Rt as an operand
//  ID_Branch      in   1      ID instruction is a conditional branch (compares in ID)
//  ID_Taken       in   1      branch/jump in ID resolves taken this cycle
//  IDEX_MemRead   in   1      EX instruction is a load
//  IDEX_RegWrite  in   1      EX instruction writes a register
//  IDEX_RegDst    in   5      EX destination register
//  EXMEM_MemRead  in   1      MEM instruction is a load
//  EXMEM_RegDst   in   5      MEM destination register
//  ID_MulStart    in   1      ID instruction is a multi-cycle MUL
//  PC_Write       out  1      1 = PC may update
//  IFID_Write     out  1      1 = IF/ID register may load
//  IFID_Flush     out  1      1 = IF/ID loads a NOP
//  IDEX_Bubble    out  1      1 = ID/EX loads a NOP (control zeroed)
//  EX_Hold        out  1      1 = ID/EX and EX/MEM hold (MUL in progress)
//  StallCycles    out  CNT_W  count of cycles with PC_Write=0, saturates at all-ones
// BEHAVIOUR
//  - Reset (Rst=0): state RUN, MulCnt=0, StallCycles=0; outputs PC_Write=1, IFID_Write=1,
//    IFID_Flush=0, IDEX_Bubble=0, EX_Hold=0 regardless of inputs.
//  - Match(a,b) := (a==b) && (a!=0); register $0 never creates a hazard.
//  - Hazard terms (combinational, same cycle):
//    LU  = IDEX_MemRead && (Match(IDEX_RegDst,IFID_Rs) || IFID_UsesRt && Match(IDEX_RegDst,IFID_Rt))
//    BR1 = ID_Branch && IDEX_RegWrite && Match(IDEX_RegDst, Rs|Rt)
//    BR2 = ID_Branch && EXMEM_MemRead && Match(EXMEM_RegDst, Rs|Rt)
//  - FSM states: RUN, MUL_BUSY. Outputs combinational from state + inputs.
//  - RUN priority: LU|BR1|BR2 > ID_Taken > ID_MulStart > none.
//    * LU|BR1|BR2: PC_Write=0, IFID_Write=0, IDEX_Bubble=1; stay RUN (re-evaluate next cycle).
//    * ID_Taken (no stall): IFID_Flush=1, PC_Write=1; ID_Taken ignored while stalled.
//    * ID_MulStart (no stall): MUL passes to EX; next state MUL_BUSY, MulCnt<=MUL_LAT-1.
//  - MUL_BUSY: PC_Write=0, IFID_Write=0, EX_Hold=1, IDEX_Bubble=0; MulCnt decrements each cycle;
//    when MulCnt==1 -> RUN next cycle (EX held exactly MUL_LAT-1 extra cycles).
//    Hazard and ID_Taken inputs ignored in MUL_BUSY; evaluated again on return to RUN.
//  - Load-use stall is exactly 1 cycle; BR1 1 cycle; BR1 followed by BR2 chains to 2 cycles.
//  - StallCycles += 1 on every cycle PC_Write=0; holds at 2^CNT_W-1.
//  - Rst asserted mid-MUL_BUSY: immediate return to RUN, counters cleared.
// STRUCTURE
//  - Shared package pipe_pkg: state encoding (RUN=1'b0, MUL_BUSY=1'b1), REG_ZERO=5'd0,
//    Match() function, MUL_LAT default.
//  - One sub-module: hazard_detect (pure combinational LU/BR1/BR2 terms); FSM, MulCnt and
//    StallCycles live in hazard_sched.
// TESTING
//  1. lw $5 in EX, add $6,$5,$7 in ID -> one cycle PC_Write=0,IFID_Write=0,IDEX_Bubble=1; StallCycles=1.
//  2. lw $0 in EX, ID reads $0 -> no stall; all outputs at reset values.
//  3. add $3 in EX, beq $3,$4 in ID; next cycle lw $3 in MEM -> 1 stall (BR1); for lw: 2 stalls (BR1 then BR2).
//  4. beq taken, no dependency -> IFID_Flush=1 one cycle, PC_Write=1; taken during stall -> no flush.
//  5. MUL_LAT=4, ID_MulStart -> EX_Hold=1 for 3 cycles, then RUN; StallCycles=3.
//  6. Rst=0 during 2nd MUL_BUSY cycle -> outputs to reset values asynchronously; StallCycles=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard scheduler:
// scheduler state encoding, register-zero constant, the register match helper
// and the default MUL occupancy.
package pipe_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned MUL_LAT_DEF = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } sched_state_e;

    // A source/destination pair only conflicts when it names a real register; $0 is hardwired.
    function automatic logic match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a == b) && (a != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms that forwarding cannot cover.
//   ifid_rs/ifid_rt/ifid_uses_rt : operands of the ID instruction
//   id_branch                    : ID instruction compares its operands in ID
//   idex_*                       : EX-stage instruction (load flag, writeback flag, dest)
//   exmem_*                      : MEM-stage instruction (load flag, dest)
//   lu_c / br1_c / br2_c         : load-use, branch-vs-EX, branch-vs-MEM-load hazards
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             id_branch,
    input  logic             idex_mem_read,
    input  logic             idex_reg_write,
    input  logic [REG_W-1:0] idex_reg_dst,
    input  logic             exmem_mem_read,
    input  logic [REG_W-1:0] exmem_reg_dst,
    output logic             lu_c,
    output logic             br1_c,
    output logic             br2_c
);

    logic ex_hits_rs;
    logic ex_hits_rt;
    logic mem_hits_src;

    always_comb begin
        ex_hits_rs   = match(idex_reg_dst, ifid_rs);
        ex_hits_rt   = match(idex_reg_dst, ifid_rt);
        mem_hits_src = match(exmem_reg_dst, ifid_rs) || match(exmem_reg_dst, ifid_rt);

        // Load data is not available until MEM, so any EX load feeding ID stalls once.
        lu_c  = idex_mem_read && (ex_hits_rs || (ifid_uses_rt && ex_hits_rt));
        // Branches compare in ID, so they need results one stage earlier than EX does.
        br1_c = id_branch && idex_reg_write && (ex_hits_rs || ex_hits_rt);
        br2_c = id_branch && exmem_mem_read && mem_hits_src;
    end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler for the 5-stage core.
//   Clk, Rst           : clock (rising edge), asynchronous active-low reset
//   IFID_* / ID_*      : ID-stage operand, branch, taken and MUL-start information
//   IDEX_* / EXMEM_*   : EX and MEM stage producer information
//   PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold : combinational pipeline controls
//   StallCycles        : saturating count of cycles with PC_Write=0
module hazard_sched
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_Taken,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       IDEX_RegDst,
    input  logic             EXMEM_MemRead,
    input  logic [4:0]       EXMEM_RegDst,
    input  logic             ID_MulStart,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             EX_Hold,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int unsigned MC_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    sched_state_e     state_q, state_d;
    logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu_c;
    logic br1_c;
    logic br2_c;
    logic stall_c;

    hazard_detect u_detect (
        .ifid_rs        (IFID_Rs),
        .ifid_rt        (IFID_Rt),
        .ifid_uses_rt   (IFID_UsesRt),
        .id_branch      (ID_Branch),
        .idex_mem_read  (IDEX_MemRead),
        .idex_reg_write (IDEX_RegWrite),
        .idex_reg_dst   (IDEX_RegDst),
        .exmem_mem_read (EXMEM_MemRead),
        .exmem_reg_dst  (EXMEM_RegDst),
        .lu_c           (lu_c),
        .br1_c          (br1_c),
        .br2_c          (br2_c)
    );

    assign stall_c = lu_c || br1_c || br2_c;

    // State, MUL occupancy and stall counter registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= RUN;
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state and pipeline controls; reset forces the idle controls regardless of inputs.
    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        stall_cnt_d = stall_cnt_q;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        EX_Hold     = 1'b0;

        if (Rst) begin
            case (state_q)
                RUN: begin
                    if (stall_c) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end else if (ID_Taken) begin
                        IFID_Flush = 1'b1;
                    end else if (ID_MulStart) begin
                        state_d   = MUL_BUSY;
                        mul_cnt_d = MC_W'(MUL_LAT - 1);
                    end
                end
                MUL_BUSY: begin
                    PC_Write   = 1'b0;
                    IFID_Write = 1'b0;
                    EX_Hold    = 1'b1;
                    mul_cnt_d  = mul_cnt_q - MC_W'(1);
                    if (mul_cnt_q == MC_W'(1)) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase

            if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;

    logic       Clk;
    logic       Rst;
    logic [4:0] IFID_Rs, IFID_Rt, IDEX_RegDst, EXMEM_RegDst;
    logic       IFID_UsesRt, ID_Branch, ID_Taken, IDEX_MemRead, IDEX_RegWrite;
    logic       EXMEM_MemRead, ID_MulStart;

    logic        pc_w, ifid_w, ifid_fl, idex_bub, ex_hold;
    logic [31:0] stall_cnt;
    logic        s_pc_w, s_ifid_w, s_ifid_fl, s_idex_bub, s_ex_hold;
    logic [1:0]  s_stall_cnt;

    typedef struct {
        string       name;
        logic [4:0]  outs;   // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold}
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    hazard_sched #(.MUL_LAT(4), .CNT_W(32)) dut (
        .Clk(Clk), .Rst(Rst),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .ID_Branch(ID_Branch), .ID_Taken(ID_Taken),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_RegDst(IDEX_RegDst),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_RegDst(EXMEM_RegDst),
        .ID_MulStart(ID_MulStart),
        .PC_Write(pc_w), .IFID_Write(ifid_w), .IFID_Flush(ifid_fl),
        .IDEX_Bubble(idex_bub), .EX_Hold(ex_hold), .StallCycles(stall_cnt)
    );

    // Narrow-counter copy sharing all stimulus, to exercise saturation.
    hazard_sched #(.MUL_LAT(4), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .ID_Branch(ID_Branch), .ID_Taken(ID_Taken),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_RegDst(IDEX_RegDst),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_RegDst(EXMEM_RegDst),
        .ID_MulStart(ID_MulStart),
        .PC_Write(s_pc_w), .IFID_Write(s_ifid_w), .IFID_Flush(s_ifid_fl),
        .IDEX_Bubble(s_idex_bub), .EX_Hold(s_ex_hold), .StallCycles(s_stall_cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every negedge with a pending expectation, compare both instances.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [4:0]  act, act_s;
            logic [1:0]  sat_exp;
            e       = exp_q.pop_front();
            act     = {pc_w, ifid_w, ifid_fl, idex_bub, ex_hold};
            act_s   = {s_pc_w, s_ifid_w, s_ifid_fl, s_idex_bub, s_ex_hold};
            sat_exp = (e.cnt > 32'd3) ? 2'd3 : e.cnt[1:0];
            checks++;
            if (act !== e.outs || stall_cnt !== e.cnt || act_s !== e.outs || s_stall_cnt !== sat_exp) begin
                failures++;
                $display("FAIL %s: got outs=%b cnt=%0d sat_outs=%b sat_cnt=%0d, want outs=%b cnt=%0d sat_cnt=%0d",
                         e.name, act, stall_cnt, act_s, s_stall_cnt, e.outs, e.cnt, sat_exp);
            end
        end
    end

    task automatic clr();
        IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0;
        ID_Branch = 1'b0; ID_Taken = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_RegDst = 5'd0;
        EXMEM_MemRead = 1'b0; EXMEM_RegDst = 5'd0;
        ID_MulStart = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [4:0] outs, input int unsigned cnt);
        exp_t e;
        e.name = name;
        e.outs = outs;
        e.cnt  = 32'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    localparam logic [4:0] IDLE  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] FLUSH = 5'b11100;
    localparam logic [4:0] MULH  = 5'b00001;

    initial begin
        Rst = 1'b0;
        clr();
        tick();

        // Reset dominates even with a load-use pattern on the inputs.
        IDEX_MemRead = 1'b1; IDEX_RegDst = 5'd5; IFID_Rs = 5'd5;
        expect_out("reset_state", IDLE, 0); tick();

        // lw $0 in EX, branch reading $0: no hazard.
        Rst = 1'b1; clr();
        IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_RegDst = 5'd0;
        IFID_UsesRt = 1'b1; ID_Branch = 1'b1;
        expect_out("reg0_no_hazard", IDLE, 0); tick();

        // lw $5 in EX, add $6,$5,$7 in ID: one load-use stall.
        clr();
        IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_RegDst = 5'd5;
        IFID_Rs = 5'd5; IFID_Rt = 5'd7; IFID_UsesRt = 1'b1;
        expect_out("lu_rs_stall", STALL, 0); tick();

        // Bubble in EX, load in MEM, non-branch consumer: forwarding covers it.
        clr();
        IFID_Rs = 5'd5; IFID_Rt = 5'd7; IFID_UsesRt = 1'b1;
        EXMEM_MemRead = 1'b1; EXMEM_RegDst = 5'd5;
        expect_out("lu_released", IDLE, 1); tick();

        // Load-use through Rt.
        clr();
        IDEX_MemRead = 1'b1; IDEX_RegDst = 5'd7;
        IFID_Rs = 5'd3; IFID_Rt = 5'd7; IFID_UsesRt = 1'b1;
        expect_out("lu_rt_stall", STALL, 1); tick();

        // Same, but ID does not read Rt as an operand.
        IFID_UsesRt = 1'b0;
        expect_out("lu_rt_unused", IDLE, 2); tick();

        // add $3 in EX, beq $3,$4 in ID: one BR1 stall.
        clr();
        ID_Branch = 1'b1; IFID_Rs = 5'd3; IFID_Rt = 5'd4;
        IDEX_RegWrite = 1'b1; IDEX_RegDst = 5'd3;
        expect_out("br1_stall", STALL, 2); tick();

        // add now in MEM (not a load): branch proceeds.
        clr();
        ID_Branch = 1'b1; IFID_Rs = 5'd3; IFID_Rt = 5'd4; EXMEM_RegDst = 5'd3;
        expect_out("br1_released", IDLE, 3); tick();

        // lw $4 in EX with beq $3,$4: BR1 then BR2.
        clr();
        ID_Branch = 1'b1; IFID_Rs = 5'd3; IFID_Rt = 5'd4; IFID_UsesRt = 1'b1;
        IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_RegDst = 5'd4;
        expect_out("br1_load_stall", STALL, 3); tick();

        // lw in MEM: BR2 stall; taken during stall must not flush.
        clr();
        ID_Branch = 1'b1; IFID_Rs = 5'd3; IFID_Rt = 5'd4; ID_Taken = 1'b1;
        EXMEM_MemRead = 1'b1; EXMEM_RegDst = 5'd4;
        expect_out("br2_stall_taken_ignored", STALL, 4); tick();

        // Dependencies gone, branch resolves taken: flush.
        clr();
        ID_Branch = 1'b1; IFID_Rs = 5'd3; IFID_Rt = 5'd4; ID_Taken = 1'b1;
        expect_out("taken_flush", FLUSH, 5); tick();

        // Taken with unrelated EX writer and a MUL start: taken wins, no MUL.
        clr();
        ID_Branch = 1'b1; IFID_Rs = 5'd3; IFID_Rt = 5'd4; ID_Taken = 1'b1;
        IDEX_RegWrite = 1'b1; IDEX_RegDst = 5'd9; ID_MulStart = 1'b1;
        expect_out("taken_over_mul", FLUSH, 5); tick();

        clr();
        expect_out("after_taken_run", IDLE, 5); tick();

        // MUL start: three busy cycles, hazards and taken ignored meanwhile.
        ID_MulStart = 1'b1;
        expect_out("mul_start", IDLE, 5); tick();
        clr();
        IDEX_MemRead = 1'b1; IDEX_RegDst = 5'd5; IFID_Rs = 5'd5; ID_Taken = 1'b1; ID_Branch = 1'b1;
        expect_out("mul_busy1", MULH, 5); tick();
        clr();
        expect_out("mul_busy2", MULH, 6); tick();
        expect_out("mul_busy3", MULH, 7); tick();
        expect_out("mul_done", IDLE, 8); tick();

        // Second MUL, reset asserted in its 2nd busy cycle.
        ID_MulStart = 1'b1;
        expect_out("mul2_start", IDLE, 8); tick();
        clr();
        expect_out("mul2_busy1", MULH, 8); tick();
        Rst = 1'b0;
        IDEX_MemRead = 1'b1; IDEX_RegDst = 5'd5; IFID_Rs = 5'd5;
        expect_out("async_reset_mid_mul", IDLE, 0); tick();

        Rst = 1'b1; clr();
        expect_out("post_reset_run", IDLE, 0); tick();

        IDEX_MemRead = 1'b1; IDEX_RegDst = 5'd5; IFID_Rs = 5'd5;
        expect_out("post_reset_lu", STALL, 0); tick();
        clr();
        expect_out("post_reset_count", IDLE, 1); tick();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
